// File: rtl/quad_pkg.sv
// Shared step encoding, FSM states and the A/B transition decoder used by the
// quadrature velocity counter.
package quad_pkg;

    localparam logic [1:0] STEP_NONE    = 2'b00;
    localparam logic [1:0] STEP_FWD     = 2'b01;
    localparam logic [1:0] STEP_REV     = 2'b10;
    localparam logic [1:0] STEP_ILLEGAL = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Gray order 00->01->11->10->00 is forward; both bits flipping is illegal.
    function automatic logic [1:0] decode_step(input logic [1:0] prev_ab,
                                               input logic [1:0] cur_ab);
        logic [1:0] step;
        step = STEP_NONE;
        if (cur_ab == prev_ab) begin
            step = STEP_NONE;
        end else if ((cur_ab ^ prev_ab) == 2'b11) begin
            step = STEP_ILLEGAL;
        end else begin
            case ({prev_ab, cur_ab})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: step = STEP_FWD;
                default:                            step = STEP_REV;
            endcase
        end
        return step;
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// Synchronises the encoder lines and turns each A/B transition into a step
// code; the INIT phase primes prev_ab so the idle level never counts.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    output logic [1:0] step_c,
    output logic       step_valid_c
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [1:0]             cur_ab;
    logic [1:0]             prev_ab;
    logic [CNT_W-1:0]       wait_cnt;
    logic                   wait_done;
    state_t                 state;
    state_t                 state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], enc_a};
            b_sync <= {b_sync[SYNC_STAGES-2:0], enc_b};
        end
    end

    assign cur_ab = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    // Tracking every cycle means prev_ab is primed by the last INIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_ab <= 2'b00;
        end else begin
            prev_ab <= cur_ab;
        end
    end

    // Counts the cycles needed to flush the synchroniser after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ST_INIT && !wait_done) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign wait_done = (wait_cnt == CNT_W'(SYNC_STAGES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (wait_done) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        step_c       = STEP_NONE;
        step_valid_c = 1'b0;
        if (state == ST_RUN) begin
            step_valid_c = 1'b1;
            step_c       = decode_step(prev_ab, cur_ab);
        end
    end

endmodule

// File: rtl/quad_velocity_counter.sv
// Quadrature encoder front end: position accumulator, saturating window count
// latched as velocity on each sample_tick, and a sticky illegal-transition flag.
module quad_velocity_counter
    import quad_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned POS_WIDTH   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enc_a,
    input  logic                          enc_b,
    input  logic                          sample_tick,
    input  logic                          clear_error,
    output logic signed [COUNT_WIDTH-1:0] velocity,
    output logic                          velocity_valid,
    output logic signed [POS_WIDTH-1:0]   position,
    output logic                          quad_error
);

    // Symmetric limits: the most-negative code is never produced.
    localparam logic signed [COUNT_WIDTH-1:0] CNT_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
    localparam logic signed [COUNT_WIDTH-1:0] CNT_MIN = -CNT_MAX;

    logic [1:0]                    step_c;
    logic                          step_valid_c;
    logic                          fwd_c;
    logic                          rev_c;
    logic                          ill_c;
    logic signed [COUNT_WIDTH-1:0] window_count;
    logic signed [COUNT_WIDTH-1:0] window_next_c;
    logic signed [COUNT_WIDTH-1:0] step_count_c;

    quad_decoder #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_decoder (
        .clk          (clk),
        .reset        (reset),
        .enc_a        (enc_a),
        .enc_b        (enc_b),
        .step_c       (step_c),
        .step_valid_c (step_valid_c)
    );

    assign fwd_c = step_valid_c && (step_c == STEP_FWD);
    assign rev_c = step_valid_c && (step_c == STEP_REV);
    assign ill_c = step_valid_c && (step_c == STEP_ILLEGAL);

    always_comb begin
        step_count_c = '0;
        if (fwd_c) begin
            step_count_c = COUNT_WIDTH'(1);
        end else if (rev_c) begin
            step_count_c = {COUNT_WIDTH{1'b1}};
        end
    end

    always_comb begin
        window_next_c = window_count;
        if (fwd_c && window_count != CNT_MAX) begin
            window_next_c = window_count + COUNT_WIDTH'(1);
        end else if (rev_c && window_count != CNT_MIN) begin
            window_next_c = window_count - COUNT_WIDTH'(1);
        end
    end

    // A tick's own step belongs to the window it opens, not the one it closes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window_count   <= '0;
            velocity       <= '0;
            velocity_valid <= 1'b0;
        end else begin
            velocity_valid <= sample_tick;
            if (sample_tick) begin
                velocity     <= window_count;
                window_count <= step_count_c;
            end else begin
                window_count <= window_next_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            position <= '0;
        end else if (fwd_c) begin
            position <= position + POS_WIDTH'(1);
        end else if (rev_c) begin
            position <= position - POS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quad_error <= 1'b0;
        end else if (ill_c) begin
            quad_error <= 1'b1;
        end else if (clear_error) begin
            quad_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_velocity_counter.sv
// Bench for quad_velocity_counter: a 16-bit and a 4-bit instance share stimulus;
// directed table, corner sequences, then random ops against an arithmetic model.
module tb_quad_velocity_counter;

    localparam int SYNC = 2;
    localparam int OP_FWD  = 0;
    localparam int OP_REV  = 1;
    localparam int OP_ILL  = 2;
    localparam int OP_TICK = 3;
    localparam int OP_CLR  = 4;

    typedef struct {
        int op;
        int n;
        int v16;
        int v4;
        int pos;
        int err;
    } vec_t;

    logic clk = 1'b0;
    logic reset, enc_a, enc_b, sample_tick, clear_error;
    logic signed [15:0] vel16;
    logic signed [3:0]  vel4;
    logic signed [31:0] pos16, pos4;
    logic vv16, vv4, err16, err4;

    int checks = 0;
    int failures = 0;
    int idx = 0;
    vec_t tbl[11];

    always #10 clk = ~clk;

    quad_velocity_counter #(.COUNT_WIDTH(16), .POS_WIDTH(32), .SYNC_STAGES(SYNC)) dut16 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .sample_tick(sample_tick), .clear_error(clear_error),
        .velocity(vel16), .velocity_valid(vv16), .position(pos16), .quad_error(err16)
    );

    quad_velocity_counter #(.COUNT_WIDTH(4), .POS_WIDTH(32), .SYNC_STAGES(SYNC)) dut4 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .sample_tick(sample_tick), .clear_error(clear_error),
        .velocity(vel4), .velocity_valid(vv4), .position(pos4), .quad_error(err4)
    );

    function automatic logic [1:0] gray(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int sat(input int x, input int w);
        int mx;
        mx = (1 << (w - 1)) - 1;
        if (x > mx) return mx;
        if (x < -mx) return -mx;
        return x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_ab();
        {enc_a, enc_b} = gray(idx);
    endtask

    // delta 1 = forward, 3 = reverse, 2 = illegal (both lines flip)
    task automatic step_op(input int delta);
        @(negedge clk);
        idx = (idx + delta) % 4;
        drive_ab();
        repeat (7) @(negedge clk);
    endtask

    task automatic tick_op(input int e16, input int e4);
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        check("valid16_high", int'(vv16), 1);
        check("valid4_high", int'(vv4), 1);
        check("velocity16", int'(vel16), e16);
        check("velocity4", int'(vel4), e4);
        @(negedge clk);
        check("valid16_one_cycle", int'(vv16), 0);
    endtask

    task automatic clr_op();
        @(negedge clk) clear_error = 1'b1;
        @(negedge clk) clear_error = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idx = 0;
        drive_ab();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (SYNC + 4) @(negedge clk);
    endtask

    initial begin
        int m_pos, m_w16, m_w4, m_err, r;

        tbl[0]  = '{OP_FWD, 10,   0,  0, 10, 0};
        tbl[1]  = '{OP_TICK, 1,  10,  7, 10, 0};
        tbl[2]  = '{OP_REV,  7,   0,  0,  3, 0};
        tbl[3]  = '{OP_TICK, 1,  -7, -7,  3, 0};
        tbl[4]  = '{OP_FWD,  9,   0,  0, 12, 0};
        tbl[5]  = '{OP_TICK, 1,   9,  7, 12, 0};
        tbl[6]  = '{OP_REV,  9,   0,  0,  3, 0};
        tbl[7]  = '{OP_TICK, 1,  -9, -7,  3, 0};
        tbl[8]  = '{OP_ILL,  1,   0,  0,  3, 1};
        tbl[9]  = '{OP_TICK, 1,   0,  0,  3, 1};
        tbl[10] = '{OP_CLR,  1,   0,  0,  3, 0};

        reset = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        sample_tick = 1'b0;
        clear_error = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_velocity", int'(vel16), 0);
        check("reset_valid", int'(vv16), 0);
        check("reset_position", int'(pos16), 0);
        check("reset_error", int'(err16), 0);
        reset = 1'b0;
        repeat (SYNC + 4) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            case (tbl[i].op)
                OP_FWD:  repeat (tbl[i].n) step_op(1);
                OP_REV:  repeat (tbl[i].n) step_op(3);
                OP_ILL:  repeat (tbl[i].n) step_op(2);
                OP_TICK: tick_op(tbl[i].v16, tbl[i].v4);
                default: clr_op();
            endcase
            check($sformatf("row%0d_position16", i), int'(pos16), tbl[i].pos);
            check($sformatf("row%0d_position4", i), int'(pos4), tbl[i].pos);
            check($sformatf("row%0d_error", i), int'(err16), tbl[i].err);
        end

        // Step whose synchronised edge coincides with the tick.
        tick_op(0, 0);
        @(negedge clk);
        idx = (idx + 1) % 4;
        drive_ab();
        repeat (SYNC) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        check("edge_on_tick_valid", int'(vv16), 1);
        check("edge_on_tick_velocity", int'(vel16), 0);
        check("edge_on_tick_position", int'(pos16), 4);
        repeat (6) @(negedge clk);
        tick_op(1, 1);

        // Illegal edge and clear_error in the same cycle: set wins.
        step_op(2);
        check("illegal_sets_error", int'(err16), 1);
        check("illegal_position", int'(pos16), 4);
        @(negedge clk);
        idx = (idx + 2) % 4;
        drive_ab();
        repeat (SYNC) @(negedge clk);
        clear_error = 1'b1;
        @(negedge clk) clear_error = 1'b0;
        check("set_wins_over_clear", int'(err16), 1);
        repeat (5) @(negedge clk);
        check("set_wins_position", int'(pos16), 4);
        clr_op();
        check("lone_clear", int'(err16), 0);

        // Back-to-back ticks: second window is zero length.
        step_op(1);
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk);
        check("b2b_first_valid", int'(vv16), 1);
        check("b2b_first_velocity", int'(vel16), 1);
        @(negedge clk) sample_tick = 1'b0;
        check("b2b_second_valid", int'(vv16), 1);
        check("b2b_second_velocity", int'(vel16), 0);
        check("b2b_second_velocity4", int'(vel4), 0);
        @(negedge clk);
        check("b2b_valid_drops", int'(vv16), 0);

        // Async reset mid-window, released with the lines idling at 11.
        repeat (3) step_op(1);
        check("pre_reset_position", int'(pos16), 8);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_position", int'(pos16), 0);
        check("async_reset_velocity", int'(vel16), 0);
        check("async_reset_valid", int'(vv16), 0);
        idx = 2;
        drive_ab();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle11_no_error", int'(err16), 0);
        check("idle11_no_count", int'(pos16), 0);
        check("no_valid_after_reset", int'(vv16), 0);
        tick_op(0, 0);

        // Random operations against an arithmetic model.
        do_reset();
        m_pos = 0;
        m_w16 = 0;
        m_w4 = 0;
        m_err = 0;
        for (int k = 0; k < 300; k++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 3) begin
                step_op(1);
                m_pos++;
                m_w16 = sat(m_w16 + 1, 16);
                m_w4 = sat(m_w4 + 1, 4);
            end else if (r <= 6) begin
                step_op(3);
                m_pos--;
                m_w16 = sat(m_w16 - 1, 16);
                m_w4 = sat(m_w4 - 1, 4);
            end else if (r == 7) begin
                tick_op(m_w16, m_w4);
                m_w16 = 0;
                m_w4 = 0;
            end else if (r == 8) begin
                step_op(2);
                m_err = 1;
            end else begin
                clr_op();
                m_err = 0;
            end
            check("rand_position16", int'(pos16), m_pos);
            check("rand_position4", int'(pos4), m_pos);
            check("rand_error16", int'(err16), m_err);
            check("rand_error4", int'(err4), m_err);
        end
        tick_op(m_w16, m_w4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
